hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_forward_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package Pipe_Buf_Reg_PKG;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// ALU operand source select for one ID/EX source register.
// EX/MEM results take priority over MEM/WB; x0 is never forwarded.
module forward_unit
  import Pipe_Buf_Reg_PKG::*;
(
  input  logic [4:0] rs_i,
  input  logic       exmem_regwrite_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       memwb_regwrite_i,
  input  logic [4:0] memwb_rd_i,
  output fwd_sel_t   sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (exmem_regwrite_i && (exmem_rd_i != REG_ZERO) && (exmem_rd_i == rs_i)) begin
      sel_o = FWD_MEM;
    end else if (memwb_regwrite_i && (memwb_rd_i != REG_ZERO) && (memwb_rd_i == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, redirect flush, halt drain.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       idex_memread,
  input  logic       idex_halt,
  input  logic [4:0] idex_rd,
  input  logic [4:0] idex_rs1,
  input  logic [4:0] idex_rs2,
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_rd,
  input  logic       ex_redirect,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b,
  output logic       pc_hold,
  output logic       ifid_hold,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  hz_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_use;
  logic [4:0]      op_rs  [2];
  fwd_sel_t        op_sel [2];

  assign op_rs[0] = idex_rs1;
  assign op_rs[1] = idex_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      forward_unit u_fwd (
        .rs_i             (op_rs[gi]),
        .exmem_regwrite_i (exmem_regwrite),
        .exmem_rd_i       (exmem_rd),
        .memwb_regwrite_i (memwb_regwrite),
        .memwb_rd_i       (memwb_rd),
        .sel_o            (op_sel[gi])
      );
    end
  endgenerate

  assign fwd_a = op_sel[0];
  assign fwd_b = op_sel[1];

  assign load_use = idex_memread && (idex_rd != REG_ZERO) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      RUN: begin
        // A redirect squashes the wrong-path instruction, including any halt in EX.
        if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else begin
          if (load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
          end
          if (idex_halt) begin
            state_d = DRAIN;
            cnt_d   = CW'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        pc_hold    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (cnt_q == '0) state_d = HALTED;
        else             cnt_d   = cnt_q - CW'(1);
      end
      HALTED: begin
        pc_hold    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        halted     = 1'b1;
      end
      default: state_d = RUN;
    endcase
    // Pipeline control stays quiet while reset is asserted.
    if (!rst_n) begin
      pc_hold    = 1'b0;
      ifid_hold  = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_evt, flush_evt;

  assign stall_evt = (state_q == RUN) && load_use && !ex_redirect;
  assign flush_evt = (state_q == RUN) && ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences,
// and random stimulus against a cycle-indexed reference model.
module tb_hazard_ctrl;
  import Pipe_Buf_Reg_PKG::*;

  localparam int D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd, idex_rs1, idex_rs2, exmem_rd, memwb_rd;
  logic       idex_memread, idex_halt, exmem_regwrite, memwb_regwrite, ex_redirect;
  fwd_sel_t   fwd_a, fwd_b;
  logic       pc_hold, ifid_hold, ifid_flush, idex_flush, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_memread(idex_memread), .idex_halt(idex_halt),
    .idex_rd(idex_rd), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .ex_redirect(ex_redirect),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the halt is remembered as the cycle index it was accepted on.
  int          cyc = 0;
  int          halt_start = -1;
  logic [31:0] stall_exp = 0;
  logic [31:0] flush_exp = 0;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       mr;
    logic [4:0] idrd, idrs1, idrs2;
    logic       exw;
    logic [4:0] exrd;
    logic       wbw;
    logic [4:0] wbrd;
    logic       red;
    logic [1:0] ea, eb;
    logic       eh, eih, eiff, eidf;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return 2'b10;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic lu_ref();
    return idex_memread && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  endfunction

  // 0 = running, 1 = draining, 2 = halted
  function automatic int phase_ref();
    if (halt_start < 0 || cyc <= halt_start) return 0;
    if (cyc - halt_start <= D) return 1;
    return 2;
  endfunction

  task automatic check_model(input string tag);
    int ph;
    logic eh, eih, eiff, eidf, ehalt;
    ph = phase_ref();
    {eh, eih, eiff, eidf, ehalt} = 5'b0;
    if (!rst_n) begin
      // all control quiet
    end else if (ph == 0) begin
      if (ex_redirect) {eiff, eidf} = 2'b11;
      else if (lu_ref()) {eh, eih, eidf} = 3'b111;
    end else begin
      {eh, eiff, eidf} = 3'b111;
      ehalt = (ph == 2);
    end
    chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(fwd_ref(idex_rs1)));
    chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(fwd_ref(idex_rs2)));
    chk({tag, ".pc_hold"}, 32'(pc_hold), 32'(eh));
    chk({tag, ".ifid_hold"}, 32'(ifid_hold), 32'(eih));
    chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(eiff));
    chk({tag, ".idex_flush"}, 32'(idex_flush), 32'(eidf));
    chk({tag, ".halted"}, 32'(halted), 32'(ehalt));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, stall_exp);
    chk({tag, ".flush_cnt"}, flush_cnt, flush_exp);
`endif
  endtask

  // Advance one clock edge and update the model with the inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (rst_n && phase_ref() == 0) begin
      if (lu_ref() && !ex_redirect && stall_exp != 32'hFFFF_FFFF) stall_exp++;
      if (ex_redirect && flush_exp != 32'hFFFF_FFFF) flush_exp++;
      if (idex_halt && !ex_redirect) halt_start = cyc;
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    {ifid_rs1, ifid_rs2, idex_rd, idex_rs1, idex_rs2, exmem_rd, memwb_rd} = '0;
    {idex_memread, idex_halt, exmem_regwrite, memwb_regwrite, ex_redirect} = '0;
  endtask

  task automatic set_vec(input vec_t v);
    ifid_rs1 = v.rs1; ifid_rs2 = v.rs2; idex_memread = v.mr; idex_halt = 1'b0;
    idex_rd = v.idrd; idex_rs1 = v.idrs1; idex_rs2 = v.idrs2;
    exmem_regwrite = v.exw; exmem_rd = v.exrd; memwb_regwrite = v.wbw; memwb_rd = v.wbrd;
    ex_redirect = v.red;
  endtask

  // Called just after a rising edge; returns just after a later rising edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    halt_start = -1;
    stall_exp = 0;
    flush_exp = 0;
    #1;
    check_model(tag);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_model(tag);
    tick();
  endtask

  initial begin
    //          rs1 rs2 mr idrd r1 r2 exw exrd wbw wbrd red  ea     eb    h  ih iff idf
    tbl[0]  = '{0,  0,  0, 0,   5, 0, 1,  5,   1,  5,   0, 2'b10, 2'b00, 0, 0, 0, 0};
    tbl[1]  = '{0,  0,  0, 0,   5, 0, 0,  5,   1,  5,   0, 2'b01, 2'b00, 0, 0, 0, 0};
    tbl[2]  = '{0,  0,  0, 0,   5, 0, 1,  0,   1,  0,   0, 2'b00, 2'b00, 0, 0, 0, 0};
    tbl[3]  = '{0,  0,  0, 0,   0, 0, 1,  0,   1,  0,   0, 2'b00, 2'b00, 0, 0, 0, 0};
    tbl[4]  = '{0,  0,  0, 0,   3, 9, 1,  3,   1,  9,   0, 2'b10, 2'b01, 0, 0, 0, 0};
    tbl[5]  = '{0,  7,  1, 7,   0, 0, 0,  0,   0,  0,   0, 2'b00, 2'b00, 1, 1, 0, 1};
    tbl[6]  = '{7,  0,  1, 7,   0, 0, 0,  0,   0,  0,   0, 2'b00, 2'b00, 1, 1, 0, 1};
    tbl[7]  = '{0,  0,  1, 0,   0, 0, 0,  0,   0,  0,   0, 2'b00, 2'b00, 0, 0, 0, 0};
    tbl[8]  = '{7,  7,  0, 7,   0, 0, 0,  0,   0,  0,   0, 2'b00, 2'b00, 0, 0, 0, 0};
    tbl[9]  = '{0,  0,  0, 0,   0, 0, 0,  0,   0,  0,   1, 2'b00, 2'b00, 0, 0, 1, 1};
    tbl[10] = '{0,  7,  1, 7,   0, 0, 0,  0,   0,  0,   1, 2'b00, 2'b00, 0, 0, 1, 1};
    tbl[11] = '{6,  8,  1, 7,   8, 6, 0,  8,   0,  6,   0, 2'b00, 2'b00, 0, 0, 0, 0};

    // Reset at time zero with live forwarding and load-use inputs.
    idle();
    rst_n = 1'b0;
    exmem_regwrite = 1; exmem_rd = 5; idex_rs1 = 5;
    idex_memread = 1; idex_rd = 7; ifid_rs2 = 7;
    #1;
    chk("rst.fwd_a_comb", 32'(fwd_a), 32'(FWD_MEM));
    chk("rst.pc_hold", 32'(pc_hold), 0);
    chk("rst.idex_flush", 32'(idex_flush), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 12; i++) begin
      set_vec(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl%0d.fwd_a", i), 32'(fwd_a), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d.fwd_b", i), 32'(fwd_b), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d.pc_hold", i), 32'(pc_hold), 32'(tbl[i].eh));
      chk($sformatf("tbl%0d.ifid_hold", i), 32'(ifid_hold), 32'(tbl[i].eih));
      chk($sformatf("tbl%0d.ifid_flush", i), 32'(ifid_flush), 32'(tbl[i].eiff));
      chk($sformatf("tbl%0d.idex_flush", i), 32'(idex_flush), 32'(tbl[i].eidf));
      check_model($sformatf("tbl%0d", i));
      tick();
    end

    // Single load-use bubble.
    idle(); do_reset("lu.rst");
    idex_memread = 1; idex_rd = 7; ifid_rs2 = 7;
    @(negedge clk);
    chk("lu.pc_hold", 32'(pc_hold), 1);
    chk("lu.ifid_hold", 32'(ifid_hold), 1);
    chk("lu.idex_flush", 32'(idex_flush), 1);
    tick();
    idle();
    @(negedge clk);
    chk("lu.after_pc_hold", 32'(pc_hold), 0);
    chk("lu.after_idex_flush", 32'(idex_flush), 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("lu.stall_cnt", stall_cnt, 1);
`endif
    tick();

    // Load-use and redirect together: redirect wins.
    do_reset("lr.rst");
    idex_memread = 1; idex_rd = 7; ifid_rs2 = 7; ex_redirect = 1;
    @(negedge clk);
    chk("lr.pc_hold", 32'(pc_hold), 0);
    chk("lr.ifid_flush", 32'(ifid_flush), 1);
    chk("lr.idex_flush", 32'(idex_flush), 1);
    tick();
    idle();
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    chk("lr.flush_cnt", flush_cnt, 1);
    chk("lr.stall_cnt", stall_cnt, 0);
`endif
    check_model("lr.after");
    tick();

    // Halt on a wrong path is discarded.
    do_reset("hr.rst");
    idex_halt = 1; ex_redirect = 1;
    step("hr.cyc0");
    idle();
    @(negedge clk);
    chk("hr.halted", 32'(halted), 0);
    chk("hr.pc_hold", 32'(pc_hold), 0);
    tick();

    // Halt: D drain cycles, then halted for good.
    do_reset("h.rst");
    idex_halt = 1;
    step("h.detect");
    idle();
    for (int i = 1; i <= D; i++) begin
      @(negedge clk);
      chk($sformatf("h.drain%0d.pc_hold", i), 32'(pc_hold), 1);
      chk($sformatf("h.drain%0d.ifid_flush", i), 32'(ifid_flush), 1);
      chk($sformatf("h.drain%0d.halted", i), 32'(halted), 0);
      tick();
    end
    for (int i = 0; i < 11; i++) begin
      if (i == 4) begin ex_redirect = 1; idex_memread = 1; idex_rd = 3; ifid_rs1 = 3; end
      @(negedge clk);
      chk($sformatf("h.halt%0d.halted", i), 32'(halted), 1);
      chk($sformatf("h.halt%0d.pc_hold", i), 32'(pc_hold), 1);
      check_model($sformatf("h.halt%0d", i));
      tick();
    end
    idle();

    // Reset asserted mid-cycle during the second drain cycle.
    do_reset("rd.rst0");
    idex_halt = 1;
    step("rd.detect");
    idle();
    step("rd.drain1");
    idex_memread = 1; idex_rd = 4; ifid_rs1 = 4;
    #2;
    rst_n = 1'b0;
    halt_start = -1; stall_exp = 0; flush_exp = 0;
    #1;
    chk("rd.pc_hold", 32'(pc_hold), 0);
    chk("rd.ifid_hold", 32'(ifid_hold), 0);
    chk("rd.ifid_flush", 32'(ifid_flush), 0);
    chk("rd.idex_flush", 32'(idex_flush), 0);
    chk("rd.halted", 32'(halted), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rd.lu_pc_hold", 32'(pc_hold), 1);
    chk("rd.lu_ifid_hold", 32'(ifid_hold), 1);
    chk("rd.lu_ifid_flush", 32'(ifid_flush), 0);
    tick();
    idle();
    step("rd.after");

    // Random traffic against the model.
    do_reset("rnd.rst");
    for (int n = 0; n < 600; n++) begin
      ifid_rs1 = 5'($urandom_range(7)); ifid_rs2 = 5'($urandom_range(7));
      idex_rd  = 5'($urandom_range(7)); idex_rs1 = 5'($urandom_range(7));
      idex_rs2 = 5'($urandom_range(7)); exmem_rd = 5'($urandom_range(7));
      memwb_rd = 5'($urandom_range(7));
      idex_memread = 1'($urandom_range(1)); exmem_regwrite = 1'($urandom_range(1));
      memwb_regwrite = 1'($urandom_range(1));
      ex_redirect = ($urandom_range(3) == 0);
      idex_halt = ($urandom_range(24) == 0);
      step($sformatf("rnd%0d", n));
      if ((phase_ref() == 2 && cyc - halt_start > D + 4) || $urandom_range(149) == 0)
        do_reset($sformatf("rnd%0d.rst", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
